// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default frame parameters shared by the UART blocks.
package uart_pkg;
  localparam int FRAME_BITS_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  // Values 0..3 are shared with uart_tx; WAIT_HIGH exists only on the receive side.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, meta} <= {RESET_VAL, RESET_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver that aligns to the start-bit midpoint,
// shifts in data LSB-first and checks the stop bit.
module uart_rx import uart_pkg::*; #(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);
  rx_state_t state, state_n;
  logic [SW-1:0] sidx, sidx_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [FRAME_BITS-1:0] shift, shift_n, data_n;
  logic rx_sync, valid_n, err_n;
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk(clk), .reset(reset), .d(rx_in), .q(rx_sync)
  );
  always_comb begin
    state_n = state;
    sidx_n  = sidx;
    bidx_n  = bidx;
    shift_n = shift;
    data_n  = rx_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (baud_tick)
      case (state)
        IDLE: if (!rx_sync) begin
          state_n = START;
          sidx_n  = '0;
        end
        START: if (sidx == S_HALF) begin
          state_n = rx_sync ? IDLE : DATA;
          sidx_n  = '0;
          bidx_n  = '0;
        end else sidx_n = sidx + 1'b1;
        // Sampling one full bit after the start midpoint lands on each data midpoint.
        DATA: if (sidx == S_LAST) begin
          shift_n[bidx] = rx_sync;
          sidx_n  = '0;
          state_n = bidx == B_LAST ? STOP : DATA;
          bidx_n  = bidx == B_LAST ? '0 : bidx + 1'b1;
        end else sidx_n = sidx + 1'b1;
        STOP: if (sidx == S_LAST) begin
          sidx_n  = '0;
          state_n = rx_sync ? IDLE : WAIT_HIGH;
          data_n  = rx_sync ? shift : rx_data;
          valid_n = rx_sync;
          err_n   = !rx_sync;
        end else sidx_n = sidx + 1'b1;
        WAIT_HIGH: state_n = rx_sync ? IDLE : WAIT_HIGH;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      sidx      <= '0;
      bidx      <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sidx      <= sidx_n;
      bidx      <= bidx_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= err_n;
    end
  assign rx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames onto rx_in and checks the received bytes,
// error pulses and busy flag against a frame-level model.
module tb_uart_rx;
  localparam int FB = 8;
  localparam int OS = 16;
  localparam int DIV = 4;
  logic clk = 1'b0, reset = 1'b1, baud_tick = 1'b0, rx_in = 1'b1, tick_en = 1'b1;
  logic [FB-1:0] rx_data;
  logic rx_valid, frame_err, rx_busy;
  int checks = 0, errors = 0, err_cnt = 0, both_cnt = 0, exp_err = 0, div_cnt = 0;
  logic [FB-1:0] got_q[$];
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] last_good = '0;

  uart_rx #(.FRAME_BITS(FB), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    baud_tick = tick_en && div_cnt == DIV - 1;
    div_cnt = (div_cnt + 1) % DIV;
  end

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_data);
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick) k++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [FB-1:0] b, input logic stop, input int gate);
    logic [FB+1:0] bits;
    int v0, e0;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < FB + 2; i++) begin
      rx_in = bits[i];
      if (i == gate) begin
        wait_ticks(5);
        tick_en = 1'b0;
        v0 = got_q.size();
        e0 = err_cnt;
        repeat (100) @(posedge clk);
        #1;
        check("gate_busy", 32'(rx_busy), 32'd1);
        check("gate_no_pulse", 32'(got_q.size() + err_cnt), 32'(v0 + e0));
        tick_en = 1'b1;
        wait_ticks(OS - 5);
      end else wait_ticks(OS);
    end
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end else exp_err++;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_ferr"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(last_good));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [FB-1:0] partial;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    wait_ticks(8);
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(OS);
    check_rx("loopback");
    check("loopback_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_ticks(4);
    check_rx("b2b");
    for (int n = 0; n < 6; n++) begin
      send_frame(FB'($urandom), 1'b1, -1);
      if ($urandom_range(1)) wait_ticks($urandom_range(20));
    end
    wait_ticks(4);
    check_rx("random");
    rx_in = 1'b0;
    wait_ticks(3);
    rx_in = 1'b1;
    wait_ticks(2 * OS);
    check_rx("glitch");
    check("glitch_busy", 32'(rx_busy), 32'd0);
    send_frame(8'h3C, 1'b0, -1);
    wait_ticks(2 * OS);
    check("ferr_wait_busy", 32'(rx_busy), 32'd1);
    check_rx("ferr");
    rx_in = 1'b1;
    wait_ticks(4);
    check("ferr_idle", 32'(rx_busy), 32'd0);
    partial = 8'h5A;
    rx_in = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx_in = partial[i];
      wait_ticks(OS);
    end
    rx_in = partial[4];
    wait_ticks(6);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    last_good = '0;
    check("midrst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    wait_ticks(2 * OS);
    check_rx("midrst");
    send_frame(8'h81, 1'b1, -1);
    wait_ticks(4);
    check_rx("after_rst");
    send_frame(FB'($urandom), 1'b1, 4);
    wait_ticks(4);
    check_rx("gating");
    check("never_both", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
